// File: rtl/raster_pkg.sv
// Shared types and constants for the raster sequencer slice.
package raster_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FETCH,
        SCAN,
        DONE
    } raster_state_t;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    localparam logic [15:0] DEFAULT_BG_COLOR = 16'h0000;

endpackage

// File: rtl/pixel_scan_counter.sv
// Raster-order pixel counter: column, row and linear address y*W+x without a multiplier.
module pixel_scan_counter #(
    parameter int DISPLAY_WIDTH  = 100,
    parameter int DISPLAY_HEIGHT = 100,
    parameter int AW             = $clog2(DISPLAY_WIDTH * DISPLAY_HEIGHT)
) (
    input  logic          clk,
    input  logic          enable,
    input  logic          clear,
    output logic [15:0]   x,
    output logic [15:0]   y,
    output logic [AW-1:0] linear,
    output logic          last
);

    assign last = (x == 16'(DISPLAY_WIDTH - 1)) && (y == 16'(DISPLAY_HEIGHT - 1));

    always_ff @(posedge clk) begin
        if (clear) begin
            x      <= '0;
            y      <= '0;
            linear <= '0;
        end else if (enable) begin
            if (last) begin
                x      <= '0;
                y      <= '0;
                linear <= '0;
            end else if (x == 16'(DISPLAY_WIDTH - 1)) begin
                x      <= '0;
                y      <= y + 16'd1;
                linear <= linear + AW'(1);
            end else begin
                x      <= x + 16'd1;
                linear <= linear + AW'(1);
            end
        end
    end

endmodule

// File: rtl/raster_sequencer.sv
// Frame sequencer: clears the framebuffer, then scans every pixel once per triangle,
// writing the fill colour wherever the external point tester reports a hit.
module raster_sequencer
    import raster_pkg::*;
#(
    parameter int          DISPLAY_WIDTH  = 100,
    parameter int          DISPLAY_HEIGHT = 100,
    parameter int          MAX_TRIS       = 256,
    parameter logic [15:0] BG_COLOR       = DEFAULT_BG_COLOR
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          frame_start,
    input  logic [$clog2(MAX_TRIS+1)-1:0]                 tri_count,
    input  logic [15:0]                                   fg_color,
    output logic [$clog2(MAX_TRIS)-1:0]                   vram_rd_addr,
    output logic [15:0]                                   scan_x,
    output logic [15:0]                                   scan_y,
    input  logic                                          tri_hit,
    output logic                                          fb_wr_en,
    output logic [$clog2(DISPLAY_WIDTH*DISPLAY_HEIGHT)-1:0] fb_wr_addr,
    output logic [15:0]                                   fb_wr_data,
    input  logic                                          fb_ready,
    output logic                                          busy,
    output logic                                          frame_done
);

    localparam int CW  = $clog2(MAX_TRIS + 1);
    localparam int VAW = $clog2(MAX_TRIS);
    localparam int AW  = $clog2(DISPLAY_WIDTH * DISPLAY_HEIGHT);

    raster_state_t state;
    logic [CW-1:0] tri_cnt_l;
    rgb565_t       color_l;
    logic [CW-1:0] next_idx;
    logic          pix_last;
    logic          scan_adv;
    logic          cnt_clear;

    pixel_scan_counter #(
        .DISPLAY_WIDTH (DISPLAY_WIDTH),
        .DISPLAY_HEIGHT(DISPLAY_HEIGHT),
        .AW            (AW)
    ) u_scan_counter (
        .clk   (clk),
        .enable(scan_adv),
        .clear (cnt_clear),
        .x     (scan_x),
        .y     (scan_y),
        .linear(fb_wr_addr),
        .last  (pix_last)
    );

    // Write enable follows the point tester in the same cycle, so it cannot be a
    // flop; it is gated by rst so nothing is written in the reset cycle.
    always_comb begin
        fb_wr_en = 1'b0;
        if (!rst) begin
            if (state == CLEAR)
                fb_wr_en = 1'b1;
            else if (state == SCAN)
                fb_wr_en = tri_hit;
        end
    end

    assign scan_adv  = ((state == CLEAR) && fb_ready) ||
                       ((state == SCAN) && (!fb_wr_en || fb_ready));
    assign cnt_clear = rst || (state == IDLE) || (state == FETCH);
    assign busy      = (state != IDLE);
    assign next_idx  = CW'(vram_rd_addr) + CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            vram_rd_addr <= '0;
            tri_cnt_l    <= '0;
            color_l      <= '0;
            fb_wr_data   <= '0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state        <= CLEAR;
                        tri_cnt_l    <= (tri_count > CW'(MAX_TRIS)) ? CW'(MAX_TRIS) : tri_count;
                        color_l      <= fg_color;
                        fb_wr_data   <= BG_COLOR;
                        vram_rd_addr <= '0;
                    end
                end
                CLEAR: begin
                    if (fb_ready && pix_last) begin
                        fb_wr_data   <= color_l;
                        vram_rd_addr <= '0;
                        if (tri_cnt_l != '0) begin
                            state <= FETCH;
                        end else begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                        end
                    end
                end
                FETCH: state <= SCAN;
                SCAN: begin
                    if (scan_adv && pix_last) begin
                        if (next_idx < tri_cnt_l) begin
                            state        <= FETCH;
                            vram_rd_addr <= vram_rd_addr + VAW'(1);
                        end else begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state        <= IDLE;
                    vram_rd_addr <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_raster_sequencer.sv
// Directed bench for raster_sequencer at W=4, H=3, MAX_TRIS=4.
module tb_raster_sequencer;

    localparam int          W  = 4;
    localparam int          H  = 3;
    localparam int          MT = 4;
    localparam logic [15:0] BG = 16'h0841;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic [2:0]  tri_count;
    logic [15:0] fg_color;
    logic [1:0]  vram_rd_addr;
    logic [15:0] scan_x;
    logic [15:0] scan_y;
    logic        tri_hit;
    logic        fb_wr_en;
    logic [3:0]  fb_wr_addr;
    logic [15:0] fb_wr_data;
    logic        fb_ready;
    logic        busy;
    logic        frame_done;

    int hit_mode;
    int errors = 0;
    int checks = 0;

    typedef struct {
        int          addr;
        logic [15:0] data;
        int          idx;
    } wr_t;

    typedef struct {
        int          tc;
        logic [15:0] fg;
        int          mode;
        bit          stall;
        bit          extra;
        int          exp_cycles;
        int          exp_writes;
    } vec_t;

    wr_t wr_q[$];
    wr_t exp_q[$];

    always #5 clk = ~clk;

    // mode 0: never hit, 1: always hit, 2: hit only at pixel (2,1)
    assign tri_hit = (hit_mode == 1) ||
                     (hit_mode == 2 && scan_x == 16'd2 && scan_y == 16'd1);

    raster_sequencer #(
        .DISPLAY_WIDTH (W),
        .DISPLAY_HEIGHT(H),
        .MAX_TRIS      (MT),
        .BG_COLOR      (BG)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .tri_count   (tri_count),
        .fg_color    (fg_color),
        .vram_rd_addr(vram_rd_addr),
        .scan_x      (scan_x),
        .scan_y      (scan_y),
        .tri_hit     (tri_hit),
        .fb_wr_en    (fb_wr_en),
        .fb_wr_addr  (fb_wr_addr),
        .fb_wr_data  (fb_wr_data),
        .fb_ready    (fb_ready),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic run_frame(input vec_t v, input int vi);
        int cyc, held, stall_left, done_cyc, n, extra_done;
        bit hit;
        wr_t w;
        tri_count = 3'(v.tc);
        fg_color  = v.fg;
        hit_mode  = v.mode;
        wr_q.delete();
        exp_q.delete();
        n = (v.tc > MT) ? MT : v.tc;
        for (int p = 0; p < W * H; p++) exp_q.push_back('{p, BG, 0});
        for (int t = 0; t < n; t++) begin
            for (int p = 0; p < W * H; p++) begin
                hit = (v.mode == 1) || (v.mode == 2 && (p % W) == 2 && (p / W) == 1);
                if (hit) exp_q.push_back('{p, v.fg, t});
            end
        end

        @(negedge clk);
        frame_start = 1'b1;
        fb_ready    = 1'b1;
        cyc         = 1;
        done_cyc    = 0;
        held        = 0;
        stall_left  = v.stall ? 3 : 0;
        while (done_cyc == 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            frame_start = v.extra && (cyc == 5);
            fb_ready    = 1'b1;
            if (fb_wr_en && fb_wr_data == v.fg && fb_wr_addr == 4'd5) begin
                held++;
                if (stall_left > 0) begin
                    fb_ready = 1'b0;
                    stall_left--;
                end
            end
            if (fb_wr_en && fb_ready) begin
                w = '{int'(fb_wr_addr), fb_wr_data, int'(vram_rd_addr)};
                wr_q.push_back(w);
            end
            if (frame_done) done_cyc = cyc;
        end
        frame_start = 1'b0;
        fb_ready    = 1'b1;

        check($sformatf("v%0d_done_cycle", vi), done_cyc, v.exp_cycles);
        check($sformatf("v%0d_write_count", vi), wr_q.size(), v.exp_writes);
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("v%0d_w%0d_addr", vi, i), wr_q[i].addr, exp_q[i].addr);
            check($sformatf("v%0d_w%0d_data", vi, i), 32'(wr_q[i].data), 32'(exp_q[i].data));
            check($sformatf("v%0d_w%0d_tri", vi, i), wr_q[i].idx, exp_q[i].idx);
        end
        if (v.stall) check($sformatf("v%0d_stall_hold", vi), held, 4);

        extra_done = 0;
        repeat (5) begin
            @(negedge clk);
            if (frame_done) extra_done++;
        end
        check($sformatf("v%0d_extra_done", vi), extra_done, 0);
        check($sformatf("v%0d_busy_after", vi), 32'(busy), 0);
        check($sformatf("v%0d_vram_after", vi), 32'(vram_rd_addr), 0);
    endtask

    vec_t vecs[6];

    initial begin
        int cnt;
        vecs[0] = '{0, 16'hF800, 1, 1'b0, 1'b0, 14, 12};
        vecs[1] = '{2, 16'h07E0, 1, 1'b0, 1'b0, 40, 36};
        vecs[2] = '{1, 16'hABCD, 1, 1'b1, 1'b0, 30, 24};
        vecs[3] = '{2, 16'h001F, 2, 1'b0, 1'b0, 40, 14};
        vecs[4] = '{1, 16'h1234, 0, 1'b0, 1'b1, 27, 12};
        vecs[5] = '{7, 16'hFFFF, 1, 1'b0, 1'b0, 66, 60};

        rst         = 1'b1;
        frame_start = 1'b0;
        tri_count   = '0;
        fg_color    = '0;
        fb_ready    = 1'b1;
        hit_mode    = 0;
        repeat (2) @(negedge clk);
        check("rst_wr_en", 32'(fb_wr_en), 0);
        check("rst_addr", 32'(fb_wr_addr), 0);
        check("rst_data", 32'(fb_wr_data), 0);
        check("rst_vram", 32'(vram_rd_addr), 0);
        check("rst_scan_xy", {scan_y, scan_x}, 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(frame_done), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_frame(vecs[i], i);

        // Reset in the middle of SCAN, then a clean frame afterwards.
        tri_count = 3'd2;
        fg_color  = 16'h5A5A;
        hit_mode  = 1;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        cnt = 0;
        while (!(fb_wr_en && fb_wr_data == 16'h5A5A && fb_wr_addr == 4'd3) && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("midscan_reached", 32'(cnt < 100), 1);
        rst = 1'b1;
        #1;
        check("rst_cycle_no_write", 32'(fb_wr_en), 0);
        @(negedge clk);
        check("midrst_wr_en", 32'(fb_wr_en), 0);
        check("midrst_addr", 32'(fb_wr_addr), 0);
        check("midrst_data", 32'(fb_wr_data), 0);
        check("midrst_vram", 32'(vram_rd_addr), 0);
        check("midrst_scan_xy", {scan_y, scan_x}, 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(frame_done), 0);
        rst = 1'b0;
        run_frame(vecs[1], 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
